// File: rtl/tcdm_g_streamer.sv
// tcdm_g_streamer: strided TCDM load/store streamer driving NPX identical ports, with a 2-entry read FIFO
module tcdm_g_streamer #(
  parameter int ADDR_SRAM_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH = DATA_WIDTH/8,
  parameter int SIZE = 1,
  parameter int NPX = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            dir_read,
  input  logic [ADDR_SRAM_WIDTH-1:0]      base_addr,
  input  logic [ADDR_SRAM_WIDTH-1:0]      stride,
  input  logic [LEN_WIDTH-1:0]            len,
  output logic                            busy,
  output logic                            done,
  output logic [NPX-1:0]                  tcdm_req,
  output logic [ADDR_SRAM_WIDTH-1:0]      tcdm_add [NPX],
  output logic [NPX-1:0]                  tcdm_wen,
  output logic [SIZE*DATA_WIDTH-1:0]      tcdm_wdata [NPX],
  output logic [SIZE*BE_WIDTH-1:0]        tcdm_be [NPX],
  input  logic [SIZE*DATA_WIDTH-1:0]      tcdm_r_rdata [NPX],
  input  logic                            in_valid,
  input  logic [NPX*SIZE*DATA_WIDTH-1:0]  in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [NPX*SIZE*DATA_WIDTH-1:0]  out_data,
  input  logic                            out_ready
);
  localparam int PW = SIZE*DATA_WIDTH;
  localparam int W = NPX*PW;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic dir_q, inflight, wr_ptr, rd_ptr;
  logic [ADDR_SRAM_WIDTH-1:0] stride_q, cur_addr;
  logic [LEN_WIDTH-1:0] len_q, cnt;
  logic [W-1:0] fifo [2];
  logic [W-1:0] rdata;
  logic [1:0] fifo_count;
  logic accept, issue, last, push, pop;
  assign accept = state == IDLE && start;
  assign in_ready = state == RUN && !dir_q;
  assign out_valid = fifo_count != 2'd0;
  assign out_data = fifo[rd_ptr];
  assign pop = out_valid && out_ready;
  assign push = inflight;
  assign issue = state == RUN && (dir_q ? ({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2 : in_valid);
  assign last = cnt == len_q - LEN_WIDTH'(1);
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign tcdm_req = {NPX{issue}};
  assign tcdm_wen = {NPX{dir_q}};
  for (genvar j = 0; j < NPX; j++) begin : g_port
    assign tcdm_add[j] = cur_addr;
    assign tcdm_wdata[j] = in_data[j*PW +: PW];
    assign tcdm_be[j] = '1;
    assign rdata[j*PW +: PW] = tcdm_r_rdata[j];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (len == '0 ? DONE : RUN) : IDLE;
      RUN:     state_n = issue && last ? (dir_q ? DRAIN : DONE) : RUN;
      DRAIN:   state_n = !inflight && fifo_count == 2'd0 ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b0;
      stride_q <= '0;
      len_q <= '0;
      cnt <= '0;
      cur_addr <= '0;
      inflight <= 1'b0;
      fifo_count <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      inflight <= issue && dir_q;
      if (accept) begin
        dir_q <= dir_read;
        stride_q <= stride;
        len_q <= len;
        cnt <= '0;
        cur_addr <= base_addr;
      end else if (issue) begin
        cnt <= cnt + LEN_WIDTH'(1);
        cur_addr <= cur_addr + stride_q;
      end
      if (push) wr_ptr <= !wr_ptr;
      if (pop) rd_ptr <= !rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= rdata;
  end
endmodule
